// File: rtl/switch_debouncer.sv
// Purpose : per-channel 2-flop synchronizer plus stable-interval debounce for DIP-switch pins.
// Latency : raw level captured at edge 0, s_db follows at edge STABLE_CYCLES+1 (STABLE_CYCLES+2 edges total).
// Backpr. : none; outputs are free-running levels and one-cycle strobes, nothing stalls upstream.
//
// Ports:
//   clk     in   1     system clock (48 MHz HSOSC domain)
//   reset   in   1     asynchronous active-high reset; deassertion must already be synchronous to clk
//   s_raw   in   N_SW  raw switch levels, asynchronous to clk
//   s_db    out  N_SW  debounced, registered switch levels
//   s_rise  out  N_SW  one-cycle strobe when s_db[i] goes 0->1
//   s_fall  out  N_SW  one-cycle strobe when s_db[i] goes 1->0
//
// Build option: define SWITCH_DEBOUNCER_EDGE_EN to get the rise/fall strobes. Without it the
// strobe outputs are tied to 0 and no edge registers exist; the port list is identical either way.

module switch_debouncer #(
    parameter int N_SW          = 4,
    parameter int STABLE_CYCLES = 240000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] s_raw,
    output logic [N_SW-1:0] s_db,
    output logic [N_SW-1:0] s_rise,
    output logic [N_SW-1:0] s_fall
);

    // Counter width is derived from the threshold and is not meant to be overridden.
    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer: two back-to-back flops, nothing in between, so the
    // first stage has a full cycle to resolve metastability.
    // ------------------------------------------------------------------
    logic [N_SW-1:0] sync1_q;
    logic [N_SW-1:0] sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= s_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: each channel counts consecutive cycles where the
    // synchronized level disagrees with the published level. Any
    // agreement clears the count, so a bounce restarts qualification
    // from zero. On the final qualifying cycle the output flips and the
    // count returns to zero in the same edge, so it never wraps.
    // ------------------------------------------------------------------
    logic [N_SW-1:0]  db_q;
    logic [N_SW-1:0]  db_d;
    logic [CNT_W-1:0] cnt_q [N_SW];
    logic [CNT_W-1:0] cnt_d [N_SW];

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                // >= rather than == keeps the count bounded even if the
                // register were ever upset past the threshold.
                if (cnt_q[i] >= CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign s_db = db_q;

    // ------------------------------------------------------------------
    // Edge strobes: computed from db_d vs db_q so they register on the
    // same edge the level changes. A channel can only flip one way per
    // edge, so rise and fall are mutually exclusive by construction.
    // ------------------------------------------------------------------
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic [N_SW-1:0] rise_q;
    logic [N_SW-1:0] fall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= db_d & ~db_q;
            fall_q <= ~db_d & db_q;
        end
    end

    assign s_rise = rise_q;
    assign s_fall = fall_q;
`else
    assign s_rise = '0;
    assign s_fall = '0;
`endif

endmodule
